e203_subsys_pll_ctrl: RTL and testbench

Sequencing controller for `e203_subsys_pll`. It owns every PLL control pin: `pll_asleep`, `pll_RESET`, `pll_OD`, `pll_M` and `pll_N`. It also drives the select of the downstream glitch-free clock mux (reference clock or PLL clock). Software changes the PLL divider configuration, and puts the PLL to sleep or wakes it, through a valid/ready handshake and a sleep-request level. The core clock is never sourced from an unlocked PLL. The block sits in the subsystem on the always-on reference-clock domain.

---
 rtl/e203_subsys_pll_ctrl_pkg.sv | 29 ++
 rtl/e203_subsys_pll_ctrl.sv | 145 ++++++++++++++
 tb/tb_e203_subsys_pll_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/e203_subsys_pll_ctrl_pkg.sv
// Shared constants and types for the E203 subsystem PLL sequencer.
package e203_subsys_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLLC_RST   = 3'd0,
    PLLC_LOCK  = 3'd1,
    PLLC_SWON  = 3'd2,
    PLLC_RUN   = 3'd3,
    PLLC_SWOFF = 3'd4,
    PLLC_SLEEP = 3'd5
  } pllc_state_e;

  localparam logic [1:0] OD_RST = 2'd1;
  localparam logic [7:0] M_RST  = 8'd32;
  localparam logic [4:0] N_RST  = 5'd1;

  typedef struct packed {
    logic [1:0] od;
    logic [7:0] m;
    logic [4:0] n;
  } pll_div_t;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned r;
    r = (a > b) ? a : b;
    return (r > c) ? r : c;
  endfunction

endpackage

// File: rtl/e203_subsys_pll_ctrl.sv
// PLL bring-up / reconfigure / sleep sequencer on the reference-clock domain.
// Drives every PLL control pin and the clock-mux select; all outputs registered.
module e203_subsys_pll_ctrl
  import e203_subsys_pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYC  = 16,
  parameter int unsigned LOCK_CYC = 1024,
  parameter int unsigned SW_CYC   = 4,
  parameter logic [1:0]  OD_RST   = e203_subsys_pll_ctrl_pkg::OD_RST,
  parameter logic [7:0]  M_RST    = e203_subsys_pll_ctrl_pkg::M_RST,
  parameter logic [4:0]  N_RST    = e203_subsys_pll_ctrl_pkg::N_RST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_od,
  input  logic [7:0] cfg_m,
  input  logic [4:0] cfg_n,
  input  logic       sleep_req,
  output logic       pll_asleep,
  output logic       pll_RESET,
  output logic [1:0] pll_OD,
  output logic [7:0] pll_M,
  output logic [4:0] pll_N,
  output logic       pll_clksel,
  output logic       pll_locked,
  output logic       busy
);

  localparam int unsigned CW = $clog2(max3(RST_CYC, LOCK_CYC, SW_CYC)) + 1;
  localparam logic [CW-1:0] RST_LD  = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_CYC - 1);
  localparam logic [CW-1:0] SW_LD   = CW'(SW_CYC - 1);
  localparam pll_div_t DIV_RST = '{od: OD_RST, m: M_RST, n: N_RST};

  pllc_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q, asleep_q, rst_q, clksel_q, locked_q, busy_q, tgt_sleep_q;
  pll_div_t      div_q, pend_q;
  pll_div_t      cfg_in;

  assign cfg_in = '{od: cfg_od, m: cfg_m, n: cfg_n};

  // Reset counts as entry into RST, so the counter starts preloaded for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLLC_RST;
      cnt_q       <= RST_LD;
      ready_q     <= 1'b0;
      asleep_q    <= 1'b0;
      rst_q       <= 1'b1;
      clksel_q    <= 1'b0;
      locked_q    <= 1'b0;
      busy_q      <= 1'b1;
      tgt_sleep_q <= 1'b0;
      div_q       <= DIV_RST;
      pend_q      <= DIV_RST;
    end else begin
      case (state_q)
        PLLC_RST: begin
          if (cnt_q == '0) begin
            state_q <= PLLC_LOCK;
            cnt_q   <= LOCK_LD;
            rst_q   <= 1'b0;
          end else cnt_q <= cnt_q - 1'b1;
        end
        PLLC_LOCK: begin
          if (cnt_q == '0) begin
            state_q  <= PLLC_SWON;
            cnt_q    <= SW_LD;
            clksel_q <= 1'b1;
          end else cnt_q <= cnt_q - 1'b1;
        end
        PLLC_SWON: begin
          if (cnt_q == '0) begin
            state_q  <= PLLC_RUN;
            locked_q <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= ~sleep_req;
          end else cnt_q <= cnt_q - 1'b1;
        end
        PLLC_RUN: begin
          // A sleep request overrides any configuration offered in the same cycle.
          if (sleep_req || (cfg_valid && ready_q)) begin
            state_q     <= PLLC_SWOFF;
            cnt_q       <= SW_LD;
            tgt_sleep_q <= sleep_req;
            if (!sleep_req) pend_q <= cfg_in;
            ready_q     <= 1'b0;
            clksel_q    <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b1;
          end else ready_q <= 1'b1;
        end
        PLLC_SWOFF: begin
          if (cnt_q == '0) begin
            rst_q <= 1'b1;
            if (tgt_sleep_q) begin
              state_q  <= PLLC_SLEEP;
              asleep_q <= 1'b1;
              busy_q   <= 1'b0;
              ready_q  <= 1'b1;
            end else begin
              state_q <= PLLC_RST;
              cnt_q   <= RST_LD;
              div_q   <= pend_q;
            end
          end else cnt_q <= cnt_q - 1'b1;
        end
        PLLC_SLEEP: begin
          if (cfg_valid && ready_q) div_q <= cfg_in;
          if (!sleep_req) begin
            state_q  <= PLLC_RST;
            cnt_q    <= RST_LD;
            asleep_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= PLLC_RST;
          cnt_q    <= RST_LD;
          rst_q    <= 1'b1;
          asleep_q <= 1'b0;
          clksel_q <= 1'b0;
          locked_q <= 1'b0;
          busy_q   <= 1'b1;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready  = ready_q;
  assign pll_asleep = asleep_q;
  assign pll_RESET  = rst_q;
  assign pll_OD     = div_q.od;
  assign pll_M      = div_q.m;
  assign pll_N      = div_q.n;
  assign pll_clksel = clksel_q;
  assign pll_locked = locked_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_e203_subsys_pll_ctrl.sv
// Directed scoreboard bench for the PLL sequencer with short cycle counts.
module tb_e203_subsys_pll_ctrl;

  typedef struct packed {
    logic       ready;
    logic       asleep;
    logic       rst;
    logic [1:0] od;
    logic [7:0] m;
    logic [4:0] n;
    logic       sel;
    logic       lck;
    logic       busy;
  } obs_t;

  logic       clk, rst_n, cfg_valid, cfg_ready, sleep_req;
  logic [1:0] cfg_od;
  logic [7:0] cfg_m;
  logic [4:0] cfg_n;
  logic       pll_asleep, pll_RESET, pll_clksel, pll_locked, busy;
  logic [1:0] pll_OD;
  logic [7:0] pll_M;
  logic [4:0] pll_N;

  int   vectors = 0;
  int   fails   = 0;
  obs_t exp_q[$];
  obs_t obs;

  e203_subsys_pll_ctrl #(.RST_CYC(4), .LOCK_CYC(8), .SW_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_od(cfg_od), .cfg_m(cfg_m), .cfg_n(cfg_n), .sleep_req(sleep_req),
    .pll_asleep(pll_asleep), .pll_RESET(pll_RESET), .pll_OD(pll_OD),
    .pll_M(pll_M), .pll_N(pll_N), .pll_clksel(pll_clksel),
    .pll_locked(pll_locked), .busy(busy)
  );

  assign obs = '{ready: cfg_ready, asleep: pll_asleep, rst: pll_RESET, od: pll_OD,
                 m: pll_M, n: pll_N, sel: pll_clksel, lck: pll_locked, busy: busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(logic rdy, logic slp, logic rs, logic [1:0] od,
                              logic [7:0] m, logic [4:0] n, logic sel, logic lk, logic bz);
    return '{ready: rdy, asleep: slp, rst: rs, od: od, m: m, n: n, sel: sel, lck: lk, busy: bz};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    obs_t e;
    e = exp_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Push expectation, advance n edges, then compare against the DUT.
  task automatic sc(input string tag, input int n, input obs_t e);
    exp_q.push_back(e);
    step(n);
    check(tag);
  endtask

  initial begin
    rst_n = 1'b1; cfg_valid = 1'b0; sleep_req = 1'b0;
    cfg_od = 2'd0; cfg_m = 8'd0; cfg_n = 5'd0;
    #2 rst_n = 1'b0;
    exp_q.push_back(mk(0,0,1,2'd1,8'd32,5'd1,0,0,1));
    #1 check("reset");
    @(negedge clk) rst_n = 1'b1;

    // Bring-up
    sc("rst_hold",  3, mk(0,0,1,2'd1,8'd32,5'd1,0,0,1));
    sc("rst_fall",  1, mk(0,0,0,2'd1,8'd32,5'd1,0,0,1));
    sc("lock_wait", 7, mk(0,0,0,2'd1,8'd32,5'd1,0,0,1));
    sc("swon",      1, mk(0,0,0,2'd1,8'd32,5'd1,1,0,1));
    sc("sw_wait",   1, mk(0,0,0,2'd1,8'd32,5'd1,1,0,1));
    sc("run",       1, mk(1,0,0,2'd1,8'd32,5'd1,1,1,0));

    // Reconfigure OD=0 M=50 N=2
    cfg_valid = 1'b1; cfg_od = 2'd0; cfg_m = 8'd50; cfg_n = 5'd2;
    sc("hs_swoff",  1, mk(0,0,0,2'd1,8'd32,5'd1,0,0,1));
    cfg_valid = 1'b0; cfg_m = 8'd0;
    sc("swoff_hold",1, mk(0,0,0,2'd1,8'd32,5'd1,0,0,1));
    sc("newdiv",    1, mk(0,0,1,2'd0,8'd50,5'd2,0,0,1));
    sc("relock_pre",13,mk(0,0,0,2'd0,8'd50,5'd2,1,0,1));
    sc("relock",    1, mk(1,0,0,2'd0,8'd50,5'd2,1,1,0));

    // Sleep with a simultaneous config that must not be consumed
    sleep_req = 1'b1; cfg_valid = 1'b1; cfg_m = 8'd99;
    sc("slp_swoff", 1, mk(0,0,0,2'd0,8'd50,5'd2,0,0,1));
    cfg_valid = 1'b0;
    sc("slp_hold",  1, mk(0,0,0,2'd0,8'd50,5'd2,0,0,1));
    sc("asleep",    1, mk(1,1,1,2'd0,8'd50,5'd2,0,0,0));

    // Config while asleep, then wake
    cfg_valid = 1'b1; cfg_od = 2'd0; cfg_m = 8'd64; cfg_n = 5'd2;
    sc("slp_cfg",   1, mk(1,1,1,2'd0,8'd64,5'd2,0,0,0));
    cfg_valid = 1'b0; sleep_req = 1'b0;
    sc("wake",      1, mk(0,0,1,2'd0,8'd64,5'd2,0,0,1));
    sc("wake_rst",  3, mk(0,0,1,2'd0,8'd64,5'd2,0,0,1));
    sc("wake_fall", 1, mk(0,0,0,2'd0,8'd64,5'd2,0,0,1));
    sc("wake_swon", 9, mk(0,0,0,2'd0,8'd64,5'd2,1,0,1));
    sc("wake_run",  1, mk(1,0,0,2'd0,8'd64,5'd2,1,1,0));

    // Reconfigure, then disturb the LOCK phase
    cfg_valid = 1'b1; cfg_od = 2'd3; cfg_m = 8'd77; cfg_n = 5'd5;
    step(1);
    cfg_valid = 1'b0;
    sc("div2",      2, mk(0,0,1,2'd3,8'd77,5'd5,0,0,1));
    sc("lock2",     4, mk(0,0,0,2'd3,8'd77,5'd5,0,0,1));
    cfg_valid = 1'b1; sleep_req = 1'b1;
    sc("lock_tog1", 2, mk(0,0,0,2'd3,8'd77,5'd5,0,0,1));
    cfg_valid = 1'b0; sleep_req = 1'b0;
    sc("lock_tog2", 1, mk(0,0,0,2'd3,8'd77,5'd5,0,0,1));

    // Asynchronous reset mid-LOCK, no clock edge needed
    #2 rst_n = 1'b0;
    exp_q.push_back(mk(0,0,1,2'd1,8'd32,5'd1,0,0,1));
    #1 check("async_rst");
    @(negedge clk) rst_n = 1'b1;
    sc("re_fall",   4, mk(0,0,0,2'd1,8'd32,5'd1,0,0,1));
    sc("re_swon",   8, mk(0,0,0,2'd1,8'd32,5'd1,1,0,1));
    sc("re_run",    2, mk(1,0,0,2'd1,8'd32,5'd1,1,1,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
